// File: rtl/r2rv_pkg.sv
// r2rv_pkg
// Shared definitions for the decode/write-back slice of the core.
//   ROB_DEPTH   : default number of reorder-buffer entries (power of two)
//   XLEN        : datapath width
//   ROB_TW      : tag width derived from ROB_DEPTH
//   rob_tag_t   : tag handed back to decode on allocation
//   rob_entry_t : one retirement-buffer slot (valid, done, we, wa, data)
package r2rv_pkg;

   localparam int ROB_DEPTH = 8;
   localparam int XLEN      = 32;
   localparam int ROB_TW    = $clog2(ROB_DEPTH);

   typedef logic [ROB_TW-1:0] rob_tag_t;

   // The data field is XLEN wide, so rob_commit must be built with the
   // package XLEN for its entry storage to line up with cdb_data.
   typedef struct packed {
      logic            valid;
      logic            done;
      logic            we;
      logic [4:0]      wa;
      logic [XLEN-1:0] data;
   } rob_entry_t;

endpackage

// File: rtl/rob_commit.sv
// rob_commit
// In-order retirement buffer feeding the register-file write port.
// Decode allocates an entry per issued instruction and gets a tag back;
// results come back on the common data bus under that tag; completed
// entries retire strictly in allocation order, one per cycle, and drive
// the registered we3/wa3/wd3 write port.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-low reset
//   alloc_valid  in   decode requests an entry
//   alloc_ready  out  an entry is free (does not look at a same-cycle commit)
//   alloc_we3    in   allocated instruction writes a register
//   alloc_wa3    in   destination register of the allocated instruction
//   alloc_tag    out  tag of the entry allocated this cycle (tail pointer)
//   cdb_valid    in   result broadcast valid
//   cdb_tag      in   tag of the broadcast result
//   cdb_data     in   broadcast result value
//   we3/wa3/wd3  out  registered register-file write port
//   empty        out  no valid entries
//   count        out  number of valid entries
//
// Build option: define ROB_CDB_BYPASS_EN to let a result aimed at the head
// entry retire in the same cycle it arrives.
module rob_commit
   import r2rv_pkg::rob_entry_t;
#(
   parameter int DEPTH = r2rv_pkg::ROB_DEPTH,
   parameter int XLEN  = r2rv_pkg::XLEN,
   parameter int TW    = $clog2(DEPTH)
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            alloc_valid,
   output logic            alloc_ready,
   input  logic            alloc_we3,
   input  logic [4:0]      alloc_wa3,
   output logic [TW-1:0]   alloc_tag,
   input  logic            cdb_valid,
   input  logic [TW-1:0]   cdb_tag,
   input  logic [XLEN-1:0] cdb_data,
   output logic            we3,
   output logic [4:0]      wa3,
   output logic [XLEN-1:0] wd3,
   output logic            empty,
   output logic [TW:0]     count
);

   rob_entry_t      r_rob [DEPTH];
   logic [TW:0]     r_head;
   logic [TW:0]     r_tail;

   logic [TW-1:0]   w_headIdx;
   logic [TW-1:0]   w_tailIdx;
   logic            w_full;
   logic            w_alloc;
   logic            w_bypass;
   logic            w_commit;
   logic            w_cdbHit;
   rob_entry_t      w_headEntry;
   logic [XLEN-1:0] w_commitData;

   // Pointers carry an extra wrap bit so full and empty can be told apart
   // when the index bits match.
   assign w_headIdx   = r_head[TW-1:0];
   assign w_tailIdx   = r_tail[TW-1:0];
   assign w_full      = (w_headIdx == w_tailIdx) && (r_head[TW] != r_tail[TW]);
   assign alloc_ready = !w_full;
   assign alloc_tag   = w_tailIdx;
   assign w_alloc     = alloc_valid && !w_full;
   assign count       = r_tail - r_head;
   assign empty       = (count == '0);

   // Commit decision for the head entry. With the bypass build a result
   // addressed to a not-yet-done head retires straight from the bus, so the
   // entry never records it. A result for the slot being allocated this
   // cycle is dropped explicitly; that slot is free before the edge anyway.
   always_comb begin
      w_headEntry = r_rob[w_headIdx];
      w_bypass    = 1'b0;
`ifdef ROB_CDB_BYPASS_EN
      w_bypass    = w_headEntry.valid && !w_headEntry.done &&
                    cdb_valid && (cdb_tag == w_headIdx);
`endif
      w_commit     = (w_headEntry.valid && w_headEntry.done) || w_bypass;
      w_commitData = w_bypass ? cdb_data : w_headEntry.data;
      w_cdbHit     = cdb_valid && r_rob[cdb_tag].valid && !r_rob[cdb_tag].done &&
                     !(w_alloc && (cdb_tag == w_tailIdx)) && !w_bypass;
   end

   // Entry storage. Allocation, result capture and retirement touch
   // different slots whenever they coincide, so the order of the updates
   // below does not matter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_rob[i] <= '0;
         end
      end else begin
         if (w_cdbHit) begin
            r_rob[cdb_tag].done <= 1'b1;
            r_rob[cdb_tag].data <= cdb_data;
         end
         if (w_commit) begin
            r_rob[w_headIdx].valid <= 1'b0;
         end
         if (w_alloc) begin
            r_rob[w_tailIdx] <= '{valid: 1'b1, done: 1'b0, we: alloc_we3,
                                  wa: alloc_wa3, data: '0};
         end
      end
   end

   // Head/tail advance independently, so an allocate plus a commit in the
   // same cycle leaves count unchanged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_head <= '0;
         r_tail <= '0;
      end else begin
         if (w_commit) begin
            r_head <= r_head + 1'b1;
         end
         if (w_alloc) begin
            r_tail <= r_tail + 1'b1;
         end
      end
   end

   // Registered write port. Writes to x0 retire silently; address and data
   // hold between commits so the register file sees stable values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we3 <= 1'b0;
         wa3 <= '0;
         wd3 <= '0;
      end else begin
         we3 <= w_commit && w_headEntry.we && (w_headEntry.wa != 5'd0);
         if (w_commit) begin
            wa3 <= w_headEntry.wa;
            wd3 <= w_commitData;
         end
      end
   end

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit
// Self-checking bench for rob_commit. A queue of in-flight instructions
// (oldest first) predicts every output each cycle; directed steps cover
// the documented scenarios and a randomized phase stresses wrap-around.
module tb_rob_commit;

   localparam int DEPTH = 8;
   localparam int XLEN  = 32;
   localparam int TW    = $clog2(DEPTH);

   logic            clk;
   logic            reset;
   logic            alloc_valid;
   logic            alloc_ready;
   logic            alloc_we3;
   logic [4:0]      alloc_wa3;
   logic [TW-1:0]   alloc_tag;
   logic            cdb_valid;
   logic [TW-1:0]   cdb_tag;
   logic [XLEN-1:0] cdb_data;
   logic            we3;
   logic [4:0]      wa3;
   logic [XLEN-1:0] wd3;
   logic            empty;
   logic [TW:0]     count;

   rob_commit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_we3(alloc_we3), .alloc_wa3(alloc_wa3), .alloc_tag(alloc_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .we3(we3), .wa3(wa3), .wd3(wd3), .empty(empty), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // In-flight instruction as decode sees it.
   typedef struct {
      int        tag;
      bit        we;
      bit [4:0]  wa;
      bit        done;
      bit [31:0] data;
   } modelEntry_t;

   modelEntry_t q[$];
   int          tailTag;
   bit          expWe3;
   bit [4:0]    expWa3;
   bit [31:0]   expWd3;
   int          checks;
   int          errors;

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      checkVal("alloc_ready", alloc_ready, q.size() < DEPTH);
      checkVal("alloc_tag", alloc_tag, tailTag);
      checkVal("count", count, q.size());
      checkVal("empty", empty, q.size() == 0);
      checkVal("we3", we3, expWe3);
      checkVal("wa3", wa3, expWa3);
      checkVal("wd3", wd3, expWd3);
   endtask

   task automatic modelReset();
      q.delete();
      tailTag = 0;
      expWe3  = 1'b0;
      expWa3  = '0;
      expWd3  = '0;
   endtask

   // One clock cycle: drive, check at the falling edge, advance the model,
   // then return just after the rising edge.
   task automatic applyStimulus(input bit av, input bit awe, input bit [4:0] awa,
                                input bit cv, input int ct, input bit [31:0] cd);
      modelEntry_t e;
      bit canAlloc;
      bit doCommit;
      bit bypass;
      alloc_valid = av;
      alloc_we3   = awe;
      alloc_wa3   = awa;
      cdb_valid   = cv;
      cdb_tag     = TW'(ct);
      cdb_data    = cd;
      @(negedge clk);
      checkOutput();
      canAlloc = q.size() < DEPTH;
      doCommit = 1'b0;
      bypass   = 1'b0;
      if (q.size() > 0) begin
         if (q[0].done) begin
            doCommit = 1'b1;
         end
`ifdef ROB_CDB_BYPASS_EN
         else if (cv && q[0].tag == ct) begin
            doCommit = 1'b1;
            bypass   = 1'b1;
         end
`endif
      end
      if (cv && !bypass) begin
         for (int i = 0; i < q.size(); i++) begin
            if (q[i].tag == ct && !q[i].done) begin
               e      = q[i];
               e.done = 1'b1;
               e.data = cd;
               q[i]   = e;
            end
         end
      end
      if (av && canAlloc) begin
         e = '{tag: tailTag, we: awe, wa: awa, done: 1'b0, data: 32'h0};
         q.push_back(e);
         tailTag = (tailTag + 1) % DEPTH;
      end
      if (doCommit) begin
         e      = q.pop_front();
         expWe3 = e.we && (e.wa != 5'd0);
         expWa3 = e.wa;
         expWd3 = bypass ? cd : e.data;
      end else begin
         expWe3 = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 0, 32'h0);
      end
   endtask

   // Asynchronous reset in the middle of a cycle; outputs must clear
   // before any clock edge arrives.
   task automatic applyReset();
      reset = 1'b0;
      #1;
      modelReset();
      checkVal("rst_empty", empty, 1'b1);
      checkVal("rst_we3", we3, 1'b0);
      checkVal("rst_count", count, 0);
      checkVal("rst_ready", alloc_ready, 1'b1);
      checkVal("rst_tag", alloc_tag, 0);
      checkVal("rst_wa3", wa3, 0);
      checkVal("rst_wd3", wd3, 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int t;
      bit av;
      bit cv;
      int ct;
      checks      = 0;
      errors      = 0;
      alloc_valid = 1'b0;
      alloc_we3   = 1'b0;
      alloc_wa3   = '0;
      cdb_valid   = 1'b0;
      cdb_tag     = '0;
      cdb_data    = '0;
      reset       = 1'b1;
      modelReset();
      @(posedge clk);
      #1;
      $display("[TB] reset state");
      applyReset();

      $display("[TB] three allocations, out-of-order completion");
      applyStimulus(1, 1, 5'd1, 0, 0, 0);
      applyStimulus(1, 1, 5'd2, 0, 0, 0);
      applyStimulus(1, 1, 5'd3, 0, 0, 0);
      #1;
      checkVal("count_after3", count, 3);
      checkVal("tag_after3", alloc_tag, 3);
      applyStimulus(0, 0, 0, 1, 1, 32'hA1);
      applyStimulus(0, 0, 0, 1, 0, 32'hB0);
      idle(3);
      checkVal("tag2_pending", count, 1);
      applyStimulus(0, 0, 0, 1, 2, 32'hC2);
      idle(3);

      $display("[TB] fill, overflow attempt, single commit");
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1, 1, 5'(i + 4), 0, 0, 0);
      end
      #1;
      checkVal("full_ready", alloc_ready, 1'b0);
      checkVal("full_count", count, DEPTH);
      applyStimulus(1, 1, 5'd31, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 3, 32'h33);
      idle(2);
      for (int k = 1; k < DEPTH; k++) begin
         applyStimulus(0, 0, 0, 1, (3 + k) % DEPTH, 32'h10 * k);
      end
      idle(3);

      $display("[TB] write to x0 is suppressed");
      t = tailTag;
      applyStimulus(1, 1, 5'd0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, t, 32'hDEADBEEF);
      idle(3);

      $display("[TB] duplicate results, first one wins");
      t = tailTag;
      applyStimulus(1, 1, 5'd5, 0, 0, 0);
      applyStimulus(1, 1, 5'd6, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, (t + 1) % DEPTH, 32'h11);
      applyStimulus(0, 0, 0, 1, (t + 1) % DEPTH, 32'h22);
      applyStimulus(0, 0, 0, 1, t, 32'h55);
      idle(3);

      $display("[TB] result-to-write latency at the head");
      t = tailTag;
      applyStimulus(1, 1, 5'd7, 0, 0, 0);
      idle(1);
      applyStimulus(0, 0, 0, 1, t, 32'h77);
      #1;
`ifdef ROB_CDB_BYPASS_EN
      checkVal("lat_n1", we3, 1'b1);
`else
      checkVal("lat_n1", we3, 1'b0);
`endif
      idle(1);
      #1;
`ifdef ROB_CDB_BYPASS_EN
      checkVal("lat_n2", we3, 1'b0);
`else
      checkVal("lat_n2", we3, 1'b1);
`endif
      idle(2);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 400; n++) begin
         av = ($urandom % 3) != 0;
         cv = ($urandom % 2) != 0;
         if (q.size() > 0 && ($urandom % 4) != 0) begin
            ct = q[$urandom % q.size()].tag;
         end else begin
            ct = $urandom % DEPTH;
         end
         applyStimulus(av, 1'($urandom), 5'($urandom), cv, ct, $urandom);
      end
      for (int n = 0; n < 3 * DEPTH && q.size() > 0; n++) begin
         applyStimulus(0, 0, 0, 1, q[q.size() - 1].tag, $urandom);
      end
      idle(2);

      $display("[TB] reset with four entries pending");
      t = tailTag;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1, 5'(i + 9), 0, 0, 0);
      end
      applyStimulus(0, 0, 0, 1, t, 32'h99);
      applyReset();
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
